// File: rtl/data_mem_access_ctrl.sv
// data_mem_access_ctrl: initiator side of the byte-wide data RAM port.
// Turns one CPU load/store request (byte or 16-bit little-endian word) into
// one or two single-cycle RAM accesses and returns the load result.
// The RAM samples mem_addr/mem_data_w/mem_din on each posedge and presents
// read data on mem_dout in the following cycle.
module data_mem_access_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data_w,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  // IDLE    : waiting for a request
  // BYTE0   : RAM samples the low byte at the end of this cycle
  // BYTE1   : RAM samples the high byte; mem_dout holds the low byte of a load
  // CAPTURE : mem_dout holds the final byte of a load
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BYTE0   = 2'd1,
    BYTE1   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Request attributes latched at acceptance; the address itself lives in
  // mem_addr, which already holds it during BYTE0.
  logic acc_we;
  logic acc_word;
  logic [7:0] acc_hi;

  logic acc_we_next;
  logic acc_word_next;
  logic [7:0] acc_hi_next;

  logic done_next;
  logic [15:0] rdata_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic mem_data_w_next;
  logic [7:0] mem_din_next;

  // busy is the only output decoded straight from the state register.
  assign busy = (state != IDLE);

  // State and registered outputs; reset aborts any access in flight and
  // drops mem_data_w at once so no further RAM write can happen.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc_we     <= 1'b0;
      acc_word   <= 1'b0;
      acc_hi     <= 8'h00;
      done       <= 1'b0;
      rdata      <= 16'h0000;
      mem_addr   <= '0;
      mem_data_w <= 1'b0;
      mem_din    <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, regardless of statement order.
      state      <= state_next;
      acc_we     <= acc_we_next;
      acc_word   <= acc_word_next;
      acc_hi     <= acc_hi_next;
      done       <= done_next;
      rdata      <= rdata_next;
      mem_addr   <= mem_addr_next;
      mem_data_w <= mem_data_w_next;
      mem_din    <= mem_din_next;
    end
  end

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next      = state;
    acc_we_next     = acc_we;
    acc_word_next   = acc_word;
    acc_hi_next     = acc_hi;
    done_next       = 1'b0;
    rdata_next      = rdata;
    mem_addr_next   = mem_addr;
    mem_data_w_next = 1'b0;
    mem_din_next    = mem_din;

    unique case (state)
      IDLE: begin
        // Requests are only looked at here; anything raised while busy is
        // dropped rather than queued.
        if (req) begin
          acc_we_next     = we;
          acc_word_next   = word;
          acc_hi_next     = wdata[15:8];
          mem_addr_next   = addr;
          mem_data_w_next = we;
          mem_din_next    = wdata[7:0];
          state_next      = BYTE0;
        end
      end

      BYTE0: begin
        if (acc_word) begin
          // High byte goes to addr+1; the natural wrap handles the top of
          // the address space and odd addresses need nothing special.
          mem_addr_next   = mem_addr + ADDR_W'(1);
          mem_din_next    = acc_hi;
          mem_data_w_next = acc_we;
          state_next      = BYTE1;
        end else if (acc_we) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = CAPTURE;
        end
      end

      BYTE1: begin
        if (acc_we) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          rdata_next[7:0] = mem_dout;
          state_next      = CAPTURE;
        end
      end

      CAPTURE: begin
        // Loads only reach this state; stores never disturb rdata.
        if (acc_word) begin
          rdata_next[15:8] = mem_dout;
        end else begin
          rdata_next = {8'h00, mem_dout};
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Self-checking bench for data_mem_access_ctrl: an 8-entry byte RAM with a
// 3-bit address decode, plus a request-level reference model (byte array,
// latency table, expected load value) that every DUT observation is
// compared against.
module tb_data_mem_access_ctrl;

  localparam int ADDR_W = 16;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic              word;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              busy;
  logic              done;
  logic [15:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_w;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;

  logic              ram_reload;
  logic [7:0]        ram     [8];
  logic [7:0]        ref_mem [8];
  logic [15:0]       ref_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clk_in = ~clk_in;

  data_mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .word       (word),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_data_w (mem_data_w),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Byte RAM with single-cycle protocol; reload restores the 10,1,...,7 image.
  always @(posedge clk_in) begin
    if (ram_reload) begin
      for (int i = 0; i < 8; i++) ram[i] <= (i == 0) ? 8'd10 : 8'(i);
    end else if (mem_data_w) begin
      ram[mem_addr[2:0]] <= mem_din;
    end
    mem_dout <= ram[mem_addr[2:0]];
  end

  // Hard stop in case anything ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ref_preload();
    for (int i = 0; i < 8; i++) ref_mem[i] = (i == 0) ? 8'd10 : 8'(i);
  endtask

  // One complete access from a negedge to the negedge inside its done cycle.
  // keep holds req high while busy; noise scrambles the request inputs
  // while busy (those must be ignored).
  task automatic do_access(input bit w, input bit wd, input logic [15:0] a,
                           input logic [15:0] d, input bit keep, input bit noise,
                           input string tag);
    int n;
    int n_wr;
    logic [15:0] a1;
    logic [15:0] exp_rd;
    n    = w ? (wd ? 2 : 1) : (wd ? 3 : 2);
    n_wr = w ? (wd ? 2 : 1) : 0;
    a1   = a + 16'd1;
    if (w) begin
      ref_mem[a[2:0]] = d[7:0];
      if (wd) ref_mem[a1[2:0]] = d[15:8];
    end else begin
      ref_rdata = wd ? {ref_mem[a1[2:0]], ref_mem[a[2:0]]} : {8'h00, ref_mem[a[2:0]]};
    end
    exp_rd = ref_rdata;
    req = 1'b1; we = w; word = wd; addr = a; wdata = d;
    for (int cyc = 0; cyc <= n; cyc++) begin
      @(negedge clk_in);
      n_cmp++;
      if (busy !== (cyc < n)) begin
        n_bad++;
        $display("FAIL %s busy cyc%0d: got %b want %b", tag, cyc, busy, (cyc < n));
      end
      n_cmp++;
      if (done !== (cyc == n)) begin
        n_bad++;
        $display("FAIL %s done cyc%0d: got %b want %b", tag, cyc, done, (cyc == n));
      end
      n_cmp++;
      if (mem_data_w !== (cyc < n_wr)) begin
        n_bad++;
        $display("FAIL %s mem_data_w cyc%0d: got %b want %b", tag, cyc, mem_data_w, (cyc < n_wr));
      end
      if (cyc == 0) begin
        n_cmp++;
        if (mem_addr !== a) begin
          n_bad++;
          $display("FAIL %s mem_addr byte0: got %h want %h", tag, mem_addr, a);
        end
        if (w) begin
          n_cmp++;
          if (mem_din !== d[7:0]) begin
            n_bad++;
            $display("FAIL %s mem_din byte0: got %h want %h", tag, mem_din, d[7:0]);
          end
        end
      end
      if (cyc == 1 && wd) begin
        n_cmp++;
        if (mem_addr !== a1) begin
          n_bad++;
          $display("FAIL %s mem_addr byte1: got %h want %h", tag, mem_addr, a1);
        end
        if (w) begin
          n_cmp++;
          if (mem_din !== d[15:8]) begin
            n_bad++;
            $display("FAIL %s mem_din byte1: got %h want %h", tag, mem_din, d[15:8]);
          end
        end
      end
      if (cyc == n) begin
        n_cmp++;
        if (rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_rd);
        end
      end else if (noise) begin
        req   = keep ? 1'b1 : 1'($urandom_range(0, 1));
        we    = 1'($urandom_range(0, 1));
        word  = 1'($urandom_range(0, 1));
        addr  = 16'($urandom);
        wdata = 16'($urandom);
      end else begin
        req = keep;
      end
    end
  endtask

  // Quiet cycles: nothing may start and nothing may be written.
  task automatic idle(input int k);
    req = 1'b0;
    repeat (k) begin
      @(negedge clk_in);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_data_w !== 1'b0) begin
        n_bad++;
        $display("FAIL idle: got busy=%b done=%b mem_data_w=%b want 0/0/0", busy, done, mem_data_w);
      end
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (ram[i] !== ref_mem[i]) begin
        n_bad++;
        $display("FAIL %s ram[%0d]: got %h want %h", tag, i, ram[i], ref_mem[i]);
      end
    end
  endtask

  task automatic check_rdata_const(input logic [15:0] want, input string tag);
    n_cmp++;
    if (rdata !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, rdata, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_reload = 1'b1;
    req = 1'b0; we = 1'b0; word = 1'b0; addr = '0; wdata = '0;
    ref_preload();
    ref_rdata = 16'h0000;
    #10;
    n_cmp++;
    if ({busy, done, rdata, mem_addr, mem_data_w, mem_din} !== '0) begin
      n_bad++;
      $display("FAIL reset_held: got busy=%b done=%b rdata=%h mem_addr=%h mem_data_w=%b mem_din=%h want all 0",
               busy, done, rdata, mem_addr, mem_data_w, mem_din);
    end
    #2;
    rst = 1'b0; ram_reload = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      n_cmp++;
      if ({busy, done, rdata, mem_addr, mem_data_w, mem_din} !== '0) begin
        n_bad++;
        $display("FAIL reset_released: got busy=%b done=%b rdata=%h mem_addr=%h mem_data_w=%b mem_din=%h want all 0",
                 busy, done, rdata, mem_addr, mem_data_w, mem_din);
      end
    end
  endtask

  task automatic test_byte_load();
    do_access(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "byte_load0");
    check_rdata_const(16'h000A, "byte_load0_value");
    idle(2);
  endtask

  task automatic test_word_load();
    do_access(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, "word_load0");
    check_rdata_const(16'h010A, "word_load0_value");
    idle(1);
    do_access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, "word_load_wrap");
    check_rdata_const(16'h0A07, "word_load_wrap_value");
    idle(1);
  endtask

  task automatic test_word_store();
    do_access(1'b1, 1'b1, 16'h0003, 16'hBEEF, 1'b0, 1'b0, "word_store3");
    check_rdata_const(16'h0A07, "word_store3_rdata_kept");
    n_cmp++;
    if (ram[3] !== 8'hEF || ram[4] !== 8'hBE) begin
      n_bad++;
      $display("FAIL word_store3_ram: got %h,%h want ef,be", ram[3], ram[4]);
    end
    idle(1);
    do_access(1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b0, "word_load3");
    check_rdata_const(16'hBEEF, "word_load3_value");
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      do_access(i % 2 == 0, 1'b0, 16'($urandom), 16'($urandom), 1'b1, 1'b1, "b2b");
    end
    idle(2);
    check_ram("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    check_ram("rand");
  endtask

  task automatic test_abort();
    ram_reload = 1'b1;
    @(negedge clk_in);
    ram_reload = 1'b0;
    ref_preload();
    req = 1'b1; we = 1'b1; word = 1'b1; addr = 16'h0005; wdata = 16'h1234;
    @(negedge clk_in);
    req = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (busy !== 1'b1 || mem_data_w !== 1'b1 || mem_addr !== 16'h0006) begin
      n_bad++;
      $display("FAIL abort_in_byte1: got busy=%b mem_data_w=%b mem_addr=%h want 1/1/0006",
               busy, mem_data_w, mem_addr);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || mem_data_w !== 1'b0 || done !== 1'b0 || rdata !== 16'h0000) begin
      n_bad++;
      $display("FAIL abort_async: got busy=%b mem_data_w=%b done=%b rdata=%h want 0/0/0/0000",
               busy, mem_data_w, done, rdata);
    end
    #1;
    rst = 1'b0;
    ref_mem[5] = 8'h34;
    ref_rdata  = 16'h0000;
    idle(3);
    n_cmp++;
    if (ram[5] !== 8'h34 || ram[6] !== 8'h06) begin
      n_bad++;
      $display("FAIL abort_ram: got %h,%h want 34,06", ram[5], ram[6]);
    end
    check_ram("abort");
    do_access(1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b0, "after_abort");
    check_rdata_const(16'h0634, "after_abort_value");
    idle(2);
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_word_load();
    test_word_store();
    test_back_to_back();
    test_random();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
